// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised N-bit pseudo-random sequence generator for the pattern path.
// Fibonacci or Galois structure, two run-time selectable tap masks, step
// enable, seed loading, all-zero lock-up recovery and on-line measurement of
// the sequence period.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   en_i           advance one step this cycle
//   load_i         load seed_in_i into the state (wins over en_i)
//   seed_in_i      value for load_i
//   poly_i         tap-mask select (0 = TAP0, 1 = TAP1)
//   mode_i         0 = Fibonacci, 1 = Galois
//   q_o            current state
//   out_o          serial output, always q_o[0]
//   wrap_o         one-cycle pulse: state has returned to the start state
//   lock_o         one-cycle pulse: all-zero recovery occurred
//   period_len_o   last measured period in steps
//   plen_valid_o   period_len_o holds a measurement
// -----------------------------------------------------------------------------
module lfsr_gen #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] TAP0  = 8'hB8,
   parameter logic [WIDTH-1:0] TAP1  = 8'h8E,
   parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_in_i,
   input  logic             poly_i,
   input  logic             mode_i,
   output logic [WIDTH-1:0] q_o,
   output logic             out_o,
   output logic             wrap_o,
   output logic             lock_o,
   output logic [WIDTH-1:0] period_len_o,
   output logic             plen_valid_o
);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Fibonacci: feedback is the parity of the tapped bits, shifted in at the MSB.
   function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] m);
      return {^(s & m), s[WIDTH-1:1]};
   endfunction

   // Galois: shift right and fold the mask in whenever the bit shifted out is 1.
   function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] m);
      return (s >> 1) ^ (s[0] ? m : ZERO_W);
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
      return (c == ONES_W) ? c : c + ONE_W;
   endfunction

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] plen_q, plen_d;
   logic             plen_valid_q, plen_valid_d;
   logic             wrap_q, wrap_d;
   logic             lock_q, lock_d;
   // Configuration used by the previous step; cfg_seen_q says whether one exists.
   logic             last_poly_q, last_poly_d;
   logic             last_mode_q, last_mode_d;
   logic             cfg_seen_q, cfg_seen_d;

   logic [WIDTH-1:0] mask_s;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] start_eff_s;
   logic [WIDTH-1:0] cnt_eff_s;
   logic             cfg_chg_s;

   // Next-state logic: load, step (with lock-up recovery and period measurement), or hold.
   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      cnt_d        = cnt_q;
      plen_d       = plen_q;
      plen_valid_d = plen_valid_q;
      wrap_d       = 1'b0;
      lock_d       = 1'b0;
      last_poly_d  = last_poly_q;
      last_mode_d  = last_mode_q;
      cfg_seen_d   = cfg_seen_q;

      mask_s    = poly_i ? TAP1 : TAP0;
      next_s    = mode_i ? gal_step(state_q, mask_s) : fib_step(state_q, mask_s);
      cfg_chg_s = cfg_seen_q && ((poly_i != last_poly_q) || (mode_i != last_mode_q));

      // A configuration change restarts the measurement from the current state.
      if (cfg_chg_s) begin
         start_eff_s = state_q;
         cnt_eff_s   = ZERO_W;
      end else begin
         start_eff_s = start_q;
         cnt_eff_s   = cnt_q;
      end

      if (load_i) begin
         state_d = seed_in_i;
         start_d = seed_in_i;
         cnt_d   = ZERO_W;
      end else if (en_i) begin
         last_poly_d = poly_i;
         last_mode_d = mode_i;
         cfg_seen_d  = 1'b1;
         if (cfg_chg_s) begin
            plen_valid_d = 1'b0;
         end else begin
            plen_valid_d = plen_valid_q;
         end

         if (state_q == ZERO_W) begin
            // Lock-up: replace the step by the recovery seed, never counts as a wrap.
            state_d = SEED;
            start_d = SEED;
            cnt_d   = ZERO_W;
            lock_d  = 1'b1;
         end else begin
            state_d = next_s;
            start_d = start_eff_s;
            if (next_s == start_eff_s) begin
               wrap_d       = 1'b1;
               plen_d       = sat_inc(cnt_eff_s);
               plen_valid_d = 1'b1;
               cnt_d        = ZERO_W;
            end else begin
               cnt_d = sat_inc(cnt_eff_s);
            end
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= SEED;
         start_q      <= SEED;
         cnt_q        <= ZERO_W;
         plen_q       <= ZERO_W;
         plen_valid_q <= 1'b0;
         wrap_q       <= 1'b0;
         lock_q       <= 1'b0;
         last_poly_q  <= 1'b0;
         last_mode_q  <= 1'b0;
         cfg_seen_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         cnt_q        <= cnt_d;
         plen_q       <= plen_d;
         plen_valid_q <= plen_valid_d;
         wrap_q       <= wrap_d;
         lock_q       <= lock_d;
         last_poly_q  <= last_poly_d;
         last_mode_q  <= last_mode_d;
         cfg_seen_q   <= cfg_seen_d;
      end
   end

   assign q_o          = state_q;
   assign out_o        = state_q[0];
   assign wrap_o       = wrap_q;
   assign lock_o       = lock_q;
   assign period_len_o = plen_q;
   assign plen_valid_o = plen_valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
// Directed self-checking bench for lfsr_gen at WIDTH=3. u_fib uses taps
// 101/011 (Fibonacci and config-change checks), u_gal uses TAP0=110 for the
// Galois sequence. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [2:0] seed_in;
   logic       poly;
   logic       mode;

   logic [2:0] f_q, g_q;
   logic       f_out, g_out;
   logic       f_wrap, g_wrap;
   logic       f_lock, g_lock;
   logic [2:0] f_plen, g_plen;
   logic       f_pv, g_pv;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0] exp_fib0 [7] = '{3'b011, 3'b101, 3'b010, 3'b001, 3'b100, 3'b110, 3'b111};
   logic [2:0] exp_fib1 [7] = '{3'b011, 3'b001, 3'b100, 3'b010, 3'b101, 3'b110, 3'b111};
   logic [2:0] exp_gal  [7] = '{3'b101, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111};
   // Poly switched to 1 while the state is 010: sequence restarts from 010.
   logic [2:0] exp_tog  [7] = '{3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b100, 3'b010};

   lfsr_gen #(.WIDTH(3), .TAP0(3'b101), .TAP1(3'b011), .SEED(3'b111)) u_fib (
      .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_in_i(seed_in),
      .poly_i(poly), .mode_i(mode), .q_o(f_q), .out_o(f_out), .wrap_o(f_wrap),
      .lock_o(f_lock), .period_len_o(f_plen), .plen_valid_o(f_pv)
   );

   lfsr_gen #(.WIDTH(3), .TAP0(3'b110), .TAP1(3'b011), .SEED(3'b111)) u_gal (
      .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_in_i(seed_in),
      .poly_i(poly), .mode_i(mode), .q_o(g_q), .out_o(g_out), .wrap_o(g_wrap),
      .lock_o(g_lock), .period_len_o(g_plen), .plen_valid_o(g_pv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; load = 1'b0; seed_in = 3'b000; poly = 1'b0; mode = 1'b0;
      tick();
      do_reset();

      // Reset state
      chk_eq("rst_q", 32'(f_q), 32'h7);
      chk_eq("rst_out", 32'(f_out), 32'h1);
      chk_eq("rst_wrap", 32'(f_wrap), 32'h0);
      chk_eq("rst_lock", 32'(f_lock), 32'h0);
      chk_eq("rst_plen", 32'(f_plen), 32'h0);
      chk_eq("rst_pv", 32'(f_pv), 32'h0);

      // Fibonacci, TAP0
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_eq($sformatf("fib0_q[%0d]", i), 32'(f_q), 32'(exp_fib0[i]));
         chk_eq($sformatf("fib0_out[%0d]", i), 32'(f_out), 32'(exp_fib0[i][0]));
         chk_eq($sformatf("fib0_wrap[%0d]", i), 32'(f_wrap), (i == 6) ? 32'h1 : 32'h0);
      end
      chk_eq("fib0_plen", 32'(f_plen), 32'h7);
      chk_eq("fib0_pv", 32'(f_pv), 32'h1);

      // Three more steps, then toggle Poly
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_eq($sformatf("pre_tog_q[%0d]", i), 32'(f_q), 32'(exp_fib0[i]));
      end
      poly = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_eq($sformatf("tog_q[%0d]", i), 32'(f_q), 32'(exp_tog[i]));
         chk_eq($sformatf("tog_wrap[%0d]", i), 32'(f_wrap), (i == 6) ? 32'h1 : 32'h0);
         chk_eq($sformatf("tog_pv[%0d]", i), 32'(f_pv), (i == 6) ? 32'h1 : 32'h0);
      end
      chk_eq("tog_plen", 32'(f_plen), 32'h7);

      // Fibonacci, TAP1 from reset
      en = 1'b0;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_eq($sformatf("fib1_q[%0d]", i), 32'(f_q), 32'(exp_fib1[i]));
         chk_eq($sformatf("fib1_wrap[%0d]", i), 32'(f_wrap), (i == 6) ? 32'h1 : 32'h0);
      end
      chk_eq("fib1_plen", 32'(f_plen), 32'h7);

      // Galois, TAP0=110 from reset
      en = 1'b0; poly = 1'b0; mode = 1'b1;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_eq($sformatf("gal_q[%0d]", i), 32'(g_q), 32'(exp_gal[i]));
         chk_eq($sformatf("gal_wrap[%0d]", i), 32'(g_wrap), (i == 6) ? 32'h1 : 32'h0);
      end
      chk_eq("gal_plen", 32'(g_plen), 32'h7);
      chk_eq("gal_pv", 32'(g_pv), 32'h1);

      // Load zero, then lock-up recovery
      en = 1'b0; mode = 1'b0;
      do_reset();
      load = 1'b1; seed_in = 3'b000;
      tick();
      chk_eq("ld0_q", 32'(f_q), 32'h0);
      chk_eq("ld0_lock", 32'(f_lock), 32'h0);
      load = 1'b0; en = 1'b1;
      tick();
      chk_eq("lock_q", 32'(f_q), 32'h7);
      chk_eq("lock_pulse", 32'(f_lock), 32'h1);
      chk_eq("lock_wrap", 32'(f_wrap), 32'h0);
      en = 1'b0;
      tick();
      chk_eq("lock_clr", 32'(f_lock), 32'h0);
      chk_eq("hold_q", 32'(f_q), 32'h7);
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_eq($sformatf("post_lock_q[%0d]", i), 32'(f_q), 32'(exp_fib0[i]));
         chk_eq($sformatf("post_lock_wrap[%0d]", i), 32'(f_wrap), (i == 6) ? 32'h1 : 32'h0);
      end
      chk_eq("post_lock_plen", 32'(f_plen), 32'h7);

      // LOAD and EN together: load wins, measurement results held
      load = 1'b1; seed_in = 3'b101;
      tick();
      chk_eq("ld_en_q", 32'(f_q), 32'h5);
      chk_eq("ld_en_pv", 32'(f_pv), 32'h1);
      chk_eq("ld_en_plen", 32'(f_plen), 32'h7);
      load = 1'b0;
      tick();
      chk_eq("after_ld_q", 32'(f_q), 32'h2);

      // Reset mid-run
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      chk_eq("mid_rst_q", 32'(f_q), 32'h7);
      chk_eq("mid_rst_wrap", 32'(f_wrap), 32'h0);
      chk_eq("mid_rst_lock", 32'(f_lock), 32'h0);
      chk_eq("mid_rst_pv", 32'(f_pv), 32'h0);
      chk_eq("mid_rst_plen", 32'(f_plen), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised N-bit pseudo-random sequence generator: the next-generation LFSR for the pattern-generation path. Supports Fibonacci and Galois structures, two run-time selectable tap masks, step enable, seed loading, all-zero lock-up recovery and on-line period measurement. It feeds the downstream test-pattern and signature logic with a parallel state word and a serial bit.

## Interface
- `WIDTH`, 8: register length in bits (≥ 3).
- `TAP0`, 8'hB8: tap mask used when `Poly`=0.
- `TAP1`, 8'h8E: tap mask used when `Poly`=1.
- `SEED`, all ones: reset value and lock-up recovery value (must be non-zero).
- `CLK` input 1: clock; all state changes on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `EN` input 1: advance one step this cycle.
- `LOAD` input 1: load `SEED_IN` into the state this cycle.
- `SEED_IN` input WIDTH: value for `LOAD`.
- `Poly` input 1: tap-mask select (0 = `TAP0`, 1 = `TAP1`).
- `MODE` input 1: 0 = Fibonacci, 1 = Galois.
- `Q` output WIDTH: current state.
- `OUT` output 1: serial output, always equals `Q[0]`.
- `WRAP` output 1: one-cycle pulse; the state has returned to the start state.
- `LOCK` output 1: one-cycle pulse; all-zero recovery occurred.
- `PERIOD_LEN` output WIDTH: last measured period in steps.
- `PLEN_VALID` output 1: `PERIOD_LEN` holds a measurement.

## Operation
- Priority per cycle: `RST` > `LOAD` > `EN` > hold.
- Reset: `Q`=`SEED`, `WRAP`=0, `LOCK`=0, `PERIOD_LEN`=0, `PLEN_VALID`=0, step counter=0, start state=`SEED`.
- Tap mask M = `Poly` ? `TAP1` : `TAP0`.
- Fibonacci step: f = XOR-reduce(`Q` & M); `Q` <= {f, `Q`[WIDTH-1:1]}.
- Galois step: `Q` <= (`Q` >> 1) ^ (`Q`[0] ? M : 0).
- Lock-up: an `EN` step taken with `Q`==0 loads `SEED` instead of computing the step, pulses `LOCK`, clears the counter, and sets start state=`SEED`. No `WRAP` is generated on that step.
- `LOAD`: `Q`<=`SEED_IN`, counter cleared, start state=`SEED_IN`. `PERIOD_LEN` and `PLEN_VALID` are held. Loading zero is permitted; recovery occurs at the next step.
- Period measurement on each normal step:
  - If next `Q` == start state: `WRAP`=1, `PERIOD_LEN`<=counter+1, `PLEN_VALID`<=1, counter<=0.
  - Otherwise counter<=counter+1, saturating at all-ones.
- Configuration change: if `Poly` or `MODE` differs from its value at the previous step, that step first clears the counter and sets start state=current `Q`. It then steps with the new configuration. `PLEN_VALID` drops to 0 until the next `WRAP`.
- `Poly`/`MODE` have effect only on `EN` cycles. Mask validity (maximal length, tap bit 0 set for Fibonacci, tap bit WIDTH-1 set for Galois) is the user's responsibility.

## Timing
- All outputs are registered. `Q`/`OUT` update on the edge where `EN` or `LOAD` is sampled high.
- Latency is one cycle. `WRAP` and `LOCK` are high in the same cycle that `Q` shows the wrapped or recovered value, and low on the next cycle unless re-triggered.
- `EN` held high gives one step per clock, with no bubbles.
- `RST` in mid-sequence aborts the measurement; no flag pulses on the reset cycle.
- `LOAD` and `EN` high together: the load wins and no step occurs.

## Test plan
- Use WIDTH=3, `TAP0`=3'b101, `TAP1`=3'b011, `SEED`=3'b111 unless stated.
- Reset, `MODE`=0, `Poly`=0, `EN`=1 for 7 cycles: `Q` = 011, 101, 010, 001, 100, 110, 111. `WRAP` is high only on the 7th step; `PERIOD_LEN`=7, `PLEN_VALID`=1.
- `Poly`=1 from reset, same stimulus: `Q` = 011, 001, 100, 010, 101, 110, 111; `WRAP` on step 7; `PERIOD_LEN`=7.
- `MODE`=1, `TAP0`=3'b110 from reset: `Q` = 101, 100, 010, 001, 110, 011, 111; `WRAP` on step 7.
- `LOAD` with `SEED_IN`=000, then one `EN` step: `Q`=111, `LOCK`=1 for one cycle, `WRAP`=0, counter=0.
- Toggle `Poly` after 3 steps: `PLEN_VALID`=0 and the start state is re-captured. `WRAP` fires 7 steps later with `PERIOD_LEN`=7. Assert `RST` mid-run: next cycle `Q`=111 and all flags are 0.
